fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: issues imem reads, waits MEM_LATENCY, hands words to decode.
// Optional PERF_COUNTER_EN adds fetch_count/stall_count outputs.
module fetch_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted,
`ifdef PERF_COUNTER_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count,
`endif
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_lat_cnt;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_halted;

    logic [ADDR_W-1:0] w_redirect_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_handshake;
    logic              w_redirect_ok;

    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
    assign w_pc_inc      = r_pc + ADDR_W'(4);
    assign w_handshake   = r_instr_valid & instr_ready;
    // HALTED is sticky: only reset leaves it, so redirect is masked there.
    assign w_redirect_ok = redirect & (r_state != S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_lat_cnt     <= 3'd0;
            r_instr       <= 32'd0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else if (w_redirect_ok) begin
            // Any in-flight read is dropped; a held word counts as consumed.
            r_pc          <= w_redirect_pc;
            r_lat_cnt     <= 3'd0;
            r_instr_valid <= 1'b0;
            r_state       <= S_ISSUE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (halt) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_lat_cnt <= 3'(MEM_LATENCY);
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 3'd1;
                    if (r_lat_cnt == 3'd1) begin
                        r_instr       <= imem_data;
                        r_instr_pc    <= r_pc;
                        r_pc          <= w_pc_inc;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_HALTED: begin
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PERF_COUNTER_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else if (r_state == S_HOLD) begin
            if (w_handshake) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (!instr_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

    assign imem_en     = (r_state == S_ISSUE) & ~rst;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instance A uses MEM_LATENCY=1, instance B uses MEM_LATENCY=3.
// Handshaken words are checked against a scoreboard queue filled when each read is issued.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // Instance A signals
    logic        rst_a, ready_a, redirect_a, halt_a;
    logic [31:0] redirect_pc_a;
    logic        en_a, valid_a, halted_a;
    logic [31:0] addr_a, instr_a, ipc_a, pc_a, data_a;
    logic [31:0] fc_a, sc_a;

    // Instance B signals
    logic        rst_b, ready_b, redirect_b, halt_b;
    logic [31:0] redirect_pc_b;
    logic        en_b, valid_b, halted_b;
    logic [31:0] addr_b, instr_b, ipc_b, pc_b, data_b;
    logic [31:0] fc_b, sc_b;

    exp_t q_a[$];
    exp_t q_b[$];

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .imem_en(en_a), .imem_addr(addr_a), .imem_data(data_a),
        .instr(instr_a), .instr_pc(ipc_a), .instr_valid(valid_a), .instr_ready(ready_a),
        .redirect(redirect_a), .redirect_pc(redirect_pc_a), .halt(halt_a), .halted(halted_a),
`ifdef PERF_COUNTER_EN
        .fetch_count(fc_a), .stall_count(sc_a),
`endif
        .pc_out(pc_a)
    );

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .imem_en(en_b), .imem_addr(addr_b), .imem_data(data_b),
        .instr(instr_b), .instr_pc(ipc_b), .instr_valid(valid_b), .instr_ready(ready_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b), .halt(halt_b), .halted(halted_b),
`ifdef PERF_COUNTER_EN
        .fetch_count(fc_b), .stall_count(sc_b),
`endif
        .pc_out(pc_b)
    );

`ifndef PERF_COUNTER_EN
    assign fc_a = 32'd0;
    assign sc_a = 32'd0;
    assign fc_b = 32'd0;
    assign sc_b = 32'd0;
`endif

    // Instruction memories; garbage is returned for cycles without a read.
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        data_a    <= en_a ? mem_word(addr_a) : 32'hDEAD_BEEF;
        pipe_b[0] <= en_b ? mem_word(addr_b) : 32'hDEAD_BEEF;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign data_b = pipe_b[2];

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_a && valid_a && ready_a) begin
            chk("a_sb_nonempty", (q_a.size() != 0), 1'b1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                $display("txn A: pc=%08h instr=%08h exp_pc=%08h exp_instr=%08h", ipc_a, instr_a, e.pc, e.word);
                chk("a_sb_instr", instr_a, e.word);
                chk("a_sb_pc", ipc_a, e.pc);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_b && valid_b && ready_b) begin
            chk("b_sb_nonempty", (q_b.size() != 0), 1'b1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                $display("txn B: pc=%08h instr=%08h exp_pc=%08h exp_instr=%08h", ipc_b, instr_b, e.pc, e.word);
                chk("b_sb_instr", instr_b, e.word);
                chk("b_sb_pc", ipc_b, e.pc);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] pc);
        q_a.push_back('{word: mem_word(pc), pc: pc});
    endtask

    task automatic push_b(input logic [31:0] pc);
        q_b.push_back('{word: mem_word(pc), pc: pc});
    endtask

    initial begin
        rst_a = 1'b1; ready_a = 1'b1; redirect_a = 1'b0; halt_a = 1'b0; redirect_pc_a = 32'h0;
        rst_b = 1'b1; ready_b = 1'b1; redirect_b = 1'b0; halt_b = 1'b0; redirect_pc_b = 32'h0;

        // Reset and the post-reset bubble
        repeat (4) cyc();
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_ipc", ipc_a, 32'h0);
        chk("rst_halted", halted_a, 1'b0);
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_en", en_a, 1'b0);
        chk("rst_fc", fc_a, 32'h0);
        rst_a = 1'b0;
        #1;
        chk("idle_en", en_a, 1'b0);
        cyc();
        chk("issue0_en", en_a, 1'b1);
        chk("issue0_addr", addr_a, 32'h0);
        push_a(32'h0);
        cyc();
        chk("wait0_valid", valid_a, 1'b0);
        chk("wait0_en", en_a, 1'b0);
        cyc();
        chk("hold0_valid", valid_a, 1'b1);
        chk("hold0_instr", instr_a, 32'h1000_0000);
        chk("hold0_ipc", ipc_a, 32'h0);
        cyc();
        chk("issue4_en", en_a, 1'b1);
        chk("issue4_addr", addr_a, 32'h4);
        push_a(32'h4);

        // Backpressure: five HOLD cycles without ready
        ready_a = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", valid_a, 1'b1);
            chk("bp_instr", instr_a, 32'h1000_0001);
            chk("bp_ipc", ipc_a, 32'h4);
            chk("bp_en", en_a, 1'b0);
            chk("bp_pc", pc_a, 32'h8);
            cyc();
        end
`ifdef PERF_COUNTER_EN
        chk("bp_stall_count", sc_a, 32'd5);
`endif
        ready_a = 1'b1;
        cyc();
        chk("issue8_en", en_a, 1'b1);
        chk("issue8_addr", addr_a, 32'h8);
        chk("issue8_valid", valid_a, 1'b0);
        push_a(32'h8);

        // Redirect coinciding with a handshake in HOLD
        cyc();
        cyc();
        chk("hold8_ipc", ipc_a, 32'h8);
        redirect_a = 1'b1;
        redirect_pc_a = 32'h100;
        cyc();
        redirect_a = 1'b0;
        chk("rd_hs_en", en_a, 1'b1);
        chk("rd_hs_addr", addr_a, 32'h100);
        chk("rd_hs_valid", valid_a, 1'b0);
`ifdef PERF_COUNTER_EN
        chk("rd_hs_fc", fc_a, 32'd3);
`endif
        push_a(32'h100);

        // Halt raised during WAIT takes effect on the next handshake
        cyc();
        halt_a = 1'b1;
        cyc();
        chk("halt_hold_valid", valid_a, 1'b1);
        chk("halt_hold_ipc", ipc_a, 32'h100);
        chk("halt_hold_halted", halted_a, 1'b0);
        cyc();
        chk("halted_1", halted_a, 1'b1);
        chk("halted_en", en_a, 1'b0);
        chk("halted_valid", valid_a, 1'b0);
        chk("halted_pc", pc_a, 32'h104);
        redirect_a = 1'b1;
        redirect_pc_a = 32'h200;
        halt_a = 1'b0;
        cyc();
        redirect_a = 1'b0;
        chk("halted_rd_halted", halted_a, 1'b1);
        chk("halted_rd_pc", pc_a, 32'h104);
        chk("halted_rd_en", en_a, 1'b0);
`ifdef PERF_COUNTER_EN
        chk("halted_fc", fc_a, 32'd4);
        chk("halted_sc", sc_a, 32'd5);
`endif
        rst_a = 1'b1;
        cyc();
        chk("unhalt_halted", halted_a, 1'b0);
        chk("unhalt_pc", pc_a, 32'h0);
        chk("unhalt_instr", instr_a, 32'h0);
        chk("unhalt_en", en_a, 1'b0);

        // Redirect in IDLE beats halt; PC wrap at top of address space
        rst_a = 1'b0;
        redirect_a = 1'b1;
        redirect_pc_a = 32'hFFFF_FFFF;
        halt_a = 1'b1;
        cyc();
        redirect_a = 1'b0;
        halt_a = 1'b0;
        chk("wrap_issue_en", en_a, 1'b1);
        chk("wrap_issue_addr", addr_a, 32'hFFFF_FFFC);
        chk("wrap_issue_halted", halted_a, 1'b0);
        push_a(32'hFFFF_FFFC);
        cyc();
        cyc();
        chk("wrap_hold_ipc", ipc_a, 32'hFFFF_FFFC);
        chk("wrap_hold_pc", pc_a, 32'h0);
        cyc();
        chk("wrap_next_en", en_a, 1'b1);
        chk("wrap_next_addr", addr_a, 32'h0);
        push_a(32'h0);

        // Reset during WAIT discards the read
        cyc();
        rst_a = 1'b1;
        void'(q_a.pop_back());
        cyc();
        chk("rstwait_valid", valid_a, 1'b0);
        chk("rstwait_pc", pc_a, 32'h0);
        chk("rstwait_instr", instr_a, 32'h0);
        chk("rstwait_en", en_a, 1'b0);
        cyc();
        chk("rstwait_valid2", valid_a, 1'b0);

        // Instance B: redirect in the second WAIT cycle, MEM_LATENCY=3
        rst_b = 1'b0;
        #1;
        chk("b_idle_en", en_b, 1'b0);
        cyc();
        chk("b_issue0_en", en_b, 1'b1);
        chk("b_issue0_addr", addr_b, 32'h0);
        cyc();
        cyc();
        redirect_b = 1'b1;
        redirect_pc_b = 32'h0000_0043;
        cyc();
        redirect_b = 1'b0;
        chk("b_rd_en", en_b, 1'b1);
        chk("b_rd_addr", addr_b, 32'h40);
        chk("b_rd_valid", valid_b, 1'b0);
        push_b(32'h40);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("b_wait_valid", valid_b, 1'b0);
            chk("b_wait_en", en_b, 1'b0);
        end
        cyc();
        chk("b_hold_valid", valid_b, 1'b1);
        chk("b_hold_ipc", ipc_b, 32'h40);
        chk("b_hold_instr", instr_b, 32'h1000_0010);
        cyc();
        chk("b_next_en", en_b, 1'b1);
        chk("b_next_addr", addr_b, 32'h44);
        rst_b = 1'b1;
        cyc();
        cyc();

        chk("a_sb_drained", q_a.size(), 0);
        chk("b_sb_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
